// File: rtl/tcm_arb_controller_pkg.sv
// Shared definitions for the TCM arbiter: bus widths, access-size codes and
// helper functions for fault decode, byte-lane enables and read-data rotation.
package tcm_arb_controller_pkg;

  localparam int unsigned BUS_WIDTH     = 32;
  localparam int unsigned BUS_ACC_WIDTH = 2;
  localparam int unsigned BUS_ACC_CNT   = 3;
  localparam int unsigned TCM_VA_WIDTH  = 14;

  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_1B = 2'd0;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_2B = 2'd1;
  localparam logic [BUS_ACC_WIDTH-1:0] BUS_ACC_4B = 2'd2;

  // Alignment check. The unused size encoding is rejected too, so it can never
  // reach the array with an ill-defined lane mask.
  function automatic logic acc_misaligned(input logic [BUS_ACC_WIDTH-1:0] acc,
                                          input logic [1:0]               off);
    logic bad;
    unique case (acc)
      BUS_ACC_1B: bad = 1'b0;
      BUS_ACC_2B: bad = off[0];
      BUS_ACC_4B: bad = (off != 2'd0);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] acc_byte_en(input logic [BUS_ACC_WIDTH-1:0] acc,
                                             input logic [1:0]               off);
    logic [3:0] be;
    unique case (acc)
      BUS_ACC_1B: be = 4'b0001 << off;
      BUS_ACC_2B: be = 4'b0011 << off;
      default:    be = 4'b1111;
    endcase
    return be;
  endfunction

  // Low-aligned write data moved up to the addressed lanes.
  function automatic logic [BUS_WIDTH-1:0] lane_shift(input logic [BUS_WIDTH-1:0] wdata,
                                                      input logic [1:0]           off);
    return wdata << {off, 3'b000};
  endfunction

  // Rotate right by whole bytes so the addressed byte lands at bit 0.
  function automatic logic [BUS_WIDTH-1:0] rotate_rdata(input logic [BUS_WIDTH-1:0] word,
                                                        input logic [1:0]           off);
    logic [2*BUS_WIDTH-1:0] dbl;
    dbl = {word, word} >> {off, 3'b000};
    return dbl[BUS_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/tcm_arb_controller_array.sv
// Single-port word RAM for the TCM.
//   clk      clock
//   i_en     access strobe (one access per cycle)
//   i_we     1 = write, 0 = read
//   i_be     byte-lane write enables
//   i_idx    word index
//   i_wdata  lane-positioned write data
//   o_rdata  read word, registered; updated only by reads
// Contents are not reset.
module tcm_array
  import tcm_arb_controller_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned AW          = 12
) (
  input  logic                 clk,
  input  logic                 i_en,
  input  logic                 i_we,
  input  logic [3:0]           i_be,
  input  logic [AW-1:0]        i_idx,
  input  logic [BUS_WIDTH-1:0] i_wdata,
  output logic [BUS_WIDTH-1:0] o_rdata
);

  logic [BUS_WIDTH-1:0] r_mem [DEPTH_WORDS];
  logic [BUS_WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < 4; b++) begin
          if (i_be[b]) r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/tcm_arb_controller.sv
// Single-port TCM shared by an instruction-fetch port (read-only) and a
// load/store port. One array access per cycle; the losing request parks in a
// one-entry buffer for its port and is serviced the following cycle.
//   clk, rstn                   clock, synchronous active-low reset
//   i_addr/i_acc/i_req          I-port request (1-cycle pulse)
//   i_rdata/i_resp/i_fault      I-port response; fault is combinational with i_req
//   d_addr/d_w_rb/d_acc/
//   d_wdata/d_req               D-port request (1-cycle pulse)
//   d_rdata/d_resp/d_fault      D-port response; fault is combinational with d_req
// Read data is rotated so the addressed byte sits at bit 0. rdata holds between
// responses. All outputs read as zero while rstn is low.
module tcm_arb_controller
  import tcm_arb_controller_pkg::*;
#(
  parameter int unsigned VA_WIDTH    = TCM_VA_WIDTH,
  parameter int unsigned DEPTH_WORDS = 32'(1) << (VA_WIDTH - 2),
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned PRIO_RR     = 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [VA_WIDTH-1:0]      i_addr,
  input  logic [BUS_ACC_WIDTH-1:0] i_acc,
  input  logic                     i_req,
  output logic [BUS_WIDTH-1:0]     i_rdata,
  output logic                     i_resp,
  output logic                     i_fault,
  input  logic [VA_WIDTH-1:0]      d_addr,
  input  logic                     d_w_rb,
  input  logic [BUS_ACC_WIDTH-1:0] d_acc,
  input  logic [BUS_WIDTH-1:0]     d_wdata,
  input  logic                     d_req,
  output logic [BUS_WIDTH-1:0]     d_rdata,
  output logic                     d_resp,
  output logic                     d_fault
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  // Fault decode
  logic w_i_invld, w_d_invld, w_i_fault, w_d_fault, w_i_new, w_d_new;

  assign w_i_invld = acc_misaligned(i_acc, i_addr[1:0]) |
                     (32'(i_addr[VA_WIDTH-1:2]) >= DEPTH_WORDS);
  assign w_d_invld = acc_misaligned(d_acc, d_addr[1:0]) |
                     (32'(d_addr[VA_WIDTH-1:2]) >= DEPTH_WORDS);
  assign w_i_fault = i_req & w_i_invld;
  assign w_d_fault = d_req & w_d_invld;
  assign w_i_new   = i_req & ~w_i_invld;
  assign w_d_new   = d_req & ~w_d_invld;
  assign i_fault   = rstn & w_i_fault;
  assign d_fault   = rstn & w_d_fault;

  // Pending buffers
  logic                     r_i_pend_v, r_d_pend_v, r_d_pend_w_rb;
  logic [VA_WIDTH-1:0]      r_i_pend_addr, r_d_pend_addr;
  logic [BUS_ACC_WIDTH-1:0] r_i_pend_acc, r_d_pend_acc;
  logic [BUS_WIDTH-1:0]     r_d_pend_wdata;

  // Candidate per port: the parked entry if any, otherwise the live request.
  logic [VA_WIDTH-1:0]      w_i_cand_addr, w_d_cand_addr;
  logic [BUS_ACC_WIDTH-1:0] w_i_cand_acc, w_d_cand_acc;
  logic                     w_d_cand_w_rb;
  logic [BUS_WIDTH-1:0]     w_d_cand_wdata;

  assign w_i_cand_addr  = r_i_pend_v ? r_i_pend_addr  : i_addr;
  assign w_i_cand_acc   = r_i_pend_v ? r_i_pend_acc   : i_acc;
  assign w_d_cand_addr  = r_d_pend_v ? r_d_pend_addr  : d_addr;
  assign w_d_cand_acc   = r_d_pend_v ? r_d_pend_acc   : d_acc;
  assign w_d_cand_w_rb  = r_d_pend_v ? r_d_pend_w_rb  : d_w_rb;
  assign w_d_cand_wdata = r_d_pend_v ? r_d_pend_wdata : d_wdata;

  // Arbiter. r_rr_prio_d = 1 means D wins the next two-way contention.
  logic r_rr_prio_d, w_rr_prio_d_nxt;
  logic w_gnt_i, w_gnt_d, w_cap_i, w_cap_d;

  always_comb begin
    w_gnt_i         = 1'b0;
    w_gnt_d         = 1'b0;
    w_cap_i         = 1'b0;
    w_cap_d         = 1'b0;
    w_rr_prio_d_nxt = r_rr_prio_d;
    if (rstn) begin
      if (r_i_pend_v) begin
        w_gnt_i = 1'b1;
        w_cap_d = w_d_new;
      end else if (r_d_pend_v) begin
        w_gnt_d = 1'b1;
        w_cap_i = w_i_new;
      end else if (w_i_new && w_d_new) begin
        if ((PRIO_RR != 0) && !r_rr_prio_d) begin
          w_gnt_i         = 1'b1;
          w_cap_d         = 1'b1;
          w_rr_prio_d_nxt = 1'b1;
        end else begin
          w_gnt_d = 1'b1;
          w_cap_i = 1'b1;
          if (PRIO_RR != 0) w_rr_prio_d_nxt = 1'b0;
        end
      end else begin
        w_gnt_i = w_i_new;
        w_gnt_d = w_d_new;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr_prio_d    <= 1'b1;
      r_i_pend_v     <= 1'b0;
      r_i_pend_addr  <= '0;
      r_i_pend_acc   <= '0;
      r_d_pend_v     <= 1'b0;
      r_d_pend_addr  <= '0;
      r_d_pend_acc   <= '0;
      r_d_pend_w_rb  <= 1'b0;
      r_d_pend_wdata <= '0;
    end else begin
      r_rr_prio_d <= w_rr_prio_d_nxt;
      if (w_cap_i) begin
        r_i_pend_v    <= 1'b1;
        r_i_pend_addr <= i_addr;
        r_i_pend_acc  <= i_acc;
      end else if (w_gnt_i) begin
        r_i_pend_v <= 1'b0;
      end
      if (w_cap_d) begin
        r_d_pend_v     <= 1'b1;
        r_d_pend_addr  <= d_addr;
        r_d_pend_acc   <= d_acc;
        r_d_pend_w_rb  <= d_w_rb;
        r_d_pend_wdata <= d_wdata;
      end else if (w_gnt_d) begin
        r_d_pend_v <= 1'b0;
      end
    end
  end

  // Array access
  logic                     w_acc_en, w_acc_we;
  logic [VA_WIDTH-1:0]      w_acc_addr;
  logic [BUS_ACC_WIDTH-1:0] w_acc_size;
  logic [BUS_WIDTH-1:0]     w_arr_rdata;

  assign w_acc_en   = w_gnt_i | w_gnt_d;
  assign w_acc_we   = w_gnt_d & w_d_cand_w_rb;
  assign w_acc_addr = w_gnt_d ? w_d_cand_addr : w_i_cand_addr;
  assign w_acc_size = w_gnt_d ? w_d_cand_acc  : w_i_cand_acc;

  tcm_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk     (clk),
    .i_en    (w_acc_en),
    .i_we    (w_acc_we),
    .i_be    (acc_byte_en(w_acc_size, w_acc_addr[1:0])),
    .i_idx   (w_acc_addr[AW+1:2]),
    .i_wdata (lane_shift(w_d_cand_wdata, w_acc_addr[1:0])),
    .o_rdata (w_arr_rdata)
  );

  // Upper address bits only feed the range check, never the array index.
  if (VA_WIDTH > AW + 2) begin : g_hi_addr
    logic unused_acc_addr_hi;
    assign unused_acc_addr_hi = ^w_acc_addr[VA_WIDTH-1:AW+2];
  end

  // Response pipeline: stage 1 lines up with the array's registered read.
  logic                 r_s1_v, r_s1_d, r_s1_we;
  logic [1:0]           r_s1_off;
  logic [BUS_WIDTH-1:0] w_s1_rot;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1_v   <= 1'b0;
      r_s1_d   <= 1'b0;
      r_s1_we  <= 1'b0;
      r_s1_off <= '0;
    end else begin
      r_s1_v   <= w_acc_en;
      r_s1_d   <= w_gnt_d;
      r_s1_we  <= w_acc_we;
      r_s1_off <= w_acc_addr[1:0];
    end
  end

  assign w_s1_rot = rotate_rdata(w_arr_rdata, r_s1_off);

  logic                 w_out_v, w_out_d, w_out_we;
  logic [BUS_WIDTH-1:0] w_out_data;

  if (RD_LAT == 2) begin : g_lat2
    logic                 r_s2_v, r_s2_d, r_s2_we;
    logic [BUS_WIDTH-1:0] r_s2_data;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        r_s2_v    <= 1'b0;
        r_s2_d    <= 1'b0;
        r_s2_we   <= 1'b0;
        r_s2_data <= '0;
      end else begin
        r_s2_v    <= r_s1_v;
        r_s2_d    <= r_s1_d;
        r_s2_we   <= r_s1_we;
        r_s2_data <= w_s1_rot;
      end
    end
    assign w_out_v    = r_s2_v;
    assign w_out_d    = r_s2_d;
    assign w_out_we   = r_s2_we;
    assign w_out_data = r_s2_data;
  end else begin : g_lat1
    assign w_out_v    = r_s1_v;
    assign w_out_d    = r_s1_d;
    assign w_out_we   = r_s1_we;
    assign w_out_data = w_s1_rot;
  end

  // Output data: live on a read response, otherwise the last value delivered.
  logic                 w_i_rd_done, w_d_rd_done;
  logic [BUS_WIDTH-1:0] r_i_rdata, r_d_rdata;

  assign w_i_rd_done = w_out_v & ~w_out_d & ~w_out_we;
  assign w_d_rd_done = w_out_v &  w_out_d & ~w_out_we;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_i_rd_done) r_i_rdata <= w_out_data;
      if (w_d_rd_done) r_d_rdata <= w_out_data;
    end
  end

  assign i_resp  = rstn & w_out_v & ~w_out_d;
  assign d_resp  = rstn & w_out_v &  w_out_d;
  assign i_rdata = !rstn ? '0 : (w_i_rd_done ? w_out_data : r_i_rdata);
  assign d_rdata = !rstn ? '0 : (w_d_rd_done ? w_out_data : r_d_rdata);

endmodule

// File: tb/tb_tcm_arb_controller.sv
// Scoreboard bench for tcm_arb_controller. Two instances share the stimulus:
//   dut0: round-robin, RD_LAT=1     dut1: D-priority, RD_LAT=2
// Both implement 1024 words so out-of-range addresses fit in the 14-bit space.
// Expected responses (tag, data, mask, cycle) are queued at issue time and a
// negedge monitor pops and compares whenever any response pulse is seen.
module tb_tcm_arb_controller;
  import tcm_arb_controller_pkg::*;

  localparam int unsigned VA    = 14;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] ALL   = 32'hFFFF_FFFF;

  logic            clk = 1'b0;
  logic            rstn;
  logic [VA-1:0]   i_addr, d_addr;
  logic [1:0]      i_acc, d_acc;
  logic            i_req, d_req, d_w_rb;
  logic [31:0]     d_wdata;

  logic [31:0] i_rdata0, d_rdata0, i_rdata1, d_rdata1;
  logic        i_resp0, d_resp0, i_fault0, d_fault0;
  logic        i_resp1, d_resp1, i_fault1, d_fault1;

  tcm_arb_controller #(.VA_WIDTH(VA), .DEPTH_WORDS(DEPTH), .RD_LAT(1), .PRIO_RR(1)) dut0 (
    .clk(clk), .rstn(rstn),
    .i_addr(i_addr), .i_acc(i_acc), .i_req(i_req),
    .i_rdata(i_rdata0), .i_resp(i_resp0), .i_fault(i_fault0),
    .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
    .d_rdata(d_rdata0), .d_resp(d_resp0), .d_fault(d_fault0)
  );

  tcm_arb_controller #(.VA_WIDTH(VA), .DEPTH_WORDS(DEPTH), .RD_LAT(2), .PRIO_RR(0)) dut1 (
    .clk(clk), .rstn(rstn),
    .i_addr(i_addr), .i_acc(i_acc), .i_req(i_req),
    .i_rdata(i_rdata1), .i_resp(i_resp1), .i_fault(i_fault1),
    .d_addr(d_addr), .d_w_rb(d_w_rb), .d_acc(d_acc), .d_wdata(d_wdata), .d_req(d_req),
    .d_rdata(d_rdata1), .d_resp(d_resp1), .d_fault(d_fault1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  // tag: 0 dut0 I, 1 dut0 D, 2 dut1 I, 3 dut1 D
  typedef struct {
    int          tag;
    logic [31:0] data;
    logic [31:0] mask;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  function automatic string tag_name(input int t);
    case (t)
      0:       return "dut0_i";
      1:       return "dut0_d";
      2:       return "dut1_i";
      default: return "dut1_d";
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    logic [3:0]  rv;
    logic [31:0] rd [4];
    int          idx;
    exp_t        e;
    rv    = {d_resp1, i_resp1, d_resp0, i_resp0};
    rd[0] = i_rdata0;
    rd[1] = d_rdata0;
    rd[2] = i_rdata1;
    rd[3] = d_rdata1;
    for (int k = 0; k < 4; k++) begin
      if (rv[k]) begin
        n_checks++;
        idx = -1;
        for (int j = 0; j < sb.size(); j++) begin
          if (idx < 0 && sb[j].tag == k) idx = j;
        end
        if (idx < 0) begin
          n_errors++;
          $display("FAIL %s unexpected resp: got data %08h at cycle %0d, required no resp",
                   tag_name(k), rd[k], cyc);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          if (cyc != e.cyc || ((rd[k] ^ e.data) & e.mask) != 32'h0) begin
            n_errors++;
            $display("FAIL %s resp: got %08h at cycle %0d, required %08h (mask %08h) at cycle %0d",
                     tag_name(k), rd[k], cyc, e.data, e.mask, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %08h, required %08h", name, got, want);
    end
  endtask

  task automatic expect_rsp(input int tag, input logic [31:0] d, input logic [31:0] m,
                            input int lat);
    exp_t e;
    e.tag  = tag;
    e.data = d;
    e.mask = m;
    e.cyc  = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present a request set for exactly one cycle (called at posedge+1).
  task automatic drive(input logic iv, input logic [VA-1:0] ia, input logic [1:0] iacc,
                       input logic dv, input logic dw, input logic [VA-1:0] da,
                       input logic [1:0] dacc, input logic [31:0] dwd);
    i_req = iv; i_addr = ia; i_acc = iacc;
    d_req = dv; d_w_rb = dw; d_addr = da; d_acc = dacc; d_wdata = dwd;
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic d_op(input logic w, input logic [VA-1:0] a, input logic [1:0] acc,
                      input logic [31:0] wd, input logic [31:0] ed, input logic [31:0] m);
    expect_rsp(1, ed, m, 1);
    expect_rsp(3, ed, m, 2);
    drive(1'b0, '0, BUS_ACC_1B, 1'b1, w, a, acc, wd);
    idle(3);
  endtask

  task automatic i_op(input logic [VA-1:0] a, input logic [1:0] acc, input logic [31:0] ed);
    expect_rsp(0, ed, ALL, 1);
    expect_rsp(2, ed, ALL, 2);
    drive(1'b1, a, acc, 1'b0, 1'b0, '0, BUS_ACC_1B, '0);
    idle(3);
  endtask

  // Simultaneous reads with per-instance expected latencies.
  task automatic both(input logic [VA-1:0] ia, input logic [1:0] iacc, input logic [31:0] ied,
                      input logic [VA-1:0] da, input logic [1:0] dacc, input logic [31:0] ded,
                      input int li0, input int ld0, input int li1, input int ld1);
    expect_rsp(0, ied, ALL, li0);
    expect_rsp(1, ded, ALL, ld0);
    expect_rsp(2, ied, ALL, li1);
    expect_rsp(3, ded, ALL, ld1);
    drive(1'b1, ia, iacc, 1'b1, 1'b0, da, dacc, '0);
    idle(4);
  endtask

  // Requests that must fault: checks the combinational fault outputs in-cycle.
  task automatic fault_cyc(input logic iv, input logic [VA-1:0] ia, input logic [1:0] iacc,
                           input logic dv, input logic dw, input logic [VA-1:0] da,
                           input logic [1:0] dacc, input logic [31:0] dwd,
                           input logic ei, input logic ed);
    i_req = iv; i_addr = ia; i_acc = iacc;
    d_req = dv; d_w_rb = dw; d_addr = da; d_acc = dacc; d_wdata = dwd;
    #1;
    chk("i_fault0", {31'b0, i_fault0}, {31'b0, ei});
    chk("d_fault0", {31'b0, d_fault0}, {31'b0, ed});
    chk("i_fault1", {31'b0, i_fault1}, {31'b0, ei});
    chk("d_fault1", {31'b0, d_fault1}, {31'b0, ed});
    @(posedge clk);
    #1;
    i_req = 1'b0;
    d_req = 1'b0;
    idle(3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp0"},  {30'b0, i_resp0, d_resp0}, 32'h0);
    chk({tag, "_resp1"},  {30'b0, i_resp1, d_resp1}, 32'h0);
    chk({tag, "_i_rd0"},  i_rdata0, 32'h0);
    chk({tag, "_d_rd0"},  d_rdata0, 32'h0);
    chk({tag, "_i_rd1"},  i_rdata1, 32'h0);
    chk({tag, "_d_rd1"},  d_rdata1, 32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    i_req = 1'b0; i_addr = '0; i_acc = BUS_ACC_1B;
    d_req = 1'b0; d_w_rb = 1'b0; d_addr = '0; d_acc = BUS_ACC_1B; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    chk_all_zero("reset");

    // Write word, read back a single byte (rotated remainder above it)
    d_op(1'b1, 14'h100, BUS_ACC_4B, 32'hDEAD_BEEF, 32'h0, 32'h0);
    d_op(1'b0, 14'h101, BUS_ACC_1B, 32'h0, 32'hEFDE_ADBE, ALL);

    d_op(1'b1, 14'h000, BUS_ACC_4B, 32'hA5A5_0001, 32'h0, 32'h0);
    d_op(1'b1, 14'h004, BUS_ACC_4B, 32'h5A5A_0002, 32'h0, 32'h0);

    // Contention: dut0 alternates starting with D; dut1 always serves D first
    both(14'h000, BUS_ACC_4B, 32'hA5A5_0001, 14'h004, BUS_ACC_4B, 32'h5A5A_0002, 2, 1, 3, 2);
    both(14'h002, BUS_ACC_2B, 32'h0001_A5A5, 14'h007, BUS_ACC_1B, 32'h5A00_025A, 1, 2, 3, 2);
    both(14'h000, BUS_ACC_4B, 32'hA5A5_0001, 14'h004, BUS_ACC_4B, 32'h5A5A_0002, 2, 1, 3, 2);
    // Uncontended request leaves the pointer (now I) alone
    i_op(14'h003, BUS_ACC_1B, 32'hA500_01A5);
    both(14'h004, BUS_ACC_4B, 32'h5A5A_0002, 14'h000, BUS_ACC_4B, 32'hA5A5_0001, 1, 2, 3, 2);

    // Faults: misaligned and out-of-range writes must not touch word 0
    fault_cyc(1'b0, '0, BUS_ACC_1B, 1'b1, 1'b1, 14'h003, BUS_ACC_2B, ALL, 1'b0, 1'b1);
    fault_cyc(1'b0, '0, BUS_ACC_1B, 1'b1, 1'b1, 14'h002, BUS_ACC_4B, ALL, 1'b0, 1'b1);
    fault_cyc(1'b0, '0, BUS_ACC_1B, 1'b1, 1'b1, 14'h1000, BUS_ACC_4B, ALL, 1'b0, 1'b1);
    fault_cyc(1'b1, 14'h001, BUS_ACC_2B, 1'b0, 1'b0, '0, BUS_ACC_1B, '0, 1'b1, 1'b0);
    fault_cyc(1'b1, 14'h1000, BUS_ACC_1B, 1'b0, 1'b0, '0, BUS_ACC_1B, '0, 1'b1, 1'b0);
    fault_cyc(1'b1, 14'h002, BUS_ACC_4B, 1'b1, 1'b0, 14'h1001, BUS_ACC_1B, '0, 1'b1, 1'b1);
    d_op(1'b0, 14'h000, BUS_ACC_4B, 32'h0, 32'hA5A5_0001, ALL);
    // Last implemented word is legal
    d_op(1'b1, 14'hFFC, BUS_ACC_4B, 32'h0102_0304, 32'h0, 32'h0);
    d_op(1'b0, 14'hFFC, BUS_ACC_4B, 32'h0, 32'h0102_0304, ALL);

    // Partial writes touch only their lanes
    d_op(1'b1, 14'h200, BUS_ACC_4B, 32'h1122_3344, 32'h0, 32'h0);
    d_op(1'b1, 14'h201, BUS_ACC_1B, 32'hFFFF_FF55, 32'h0, 32'h0);
    d_op(1'b0, 14'h200, BUS_ACC_4B, 32'h0, 32'h1122_5544, ALL);
    d_op(1'b1, 14'h202, BUS_ACC_2B, 32'h1234_BEEF, 32'h0, 32'h0);
    d_op(1'b0, 14'h200, BUS_ACC_4B, 32'h0, 32'hBEEF_5544, ALL);

    // Read-after-write on the very next cycle from the other port
    expect_rsp(1, 32'h0, 32'h0, 1);
    expect_rsp(3, 32'h0, 32'h0, 2);
    drive(1'b0, '0, BUS_ACC_1B, 1'b1, 1'b1, 14'h300, BUS_ACC_4B, 32'hCAFE_F00D);
    expect_rsp(0, 32'hCAFE_F00D, ALL, 1);
    expect_rsp(2, 32'hCAFE_F00D, ALL, 2);
    drive(1'b1, 14'h300, BUS_ACC_4B, 1'b0, 1'b0, '0, BUS_ACC_1B, '0);
    idle(4);

    // Reset while I is parked and D is in flight: nothing may come back
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    drive(1'b1, 14'h000, BUS_ACC_4B, 1'b1, 1'b0, 14'h004, BUS_ACC_4B, '0);
    rstn = 1'b0;
    #1;
    chk_all_zero("in_reset");
    idle(2);
    rstn = 1'b1;
    idle(4);
    // Pointer back to D; array kept its contents
    both(14'h000, BUS_ACC_4B, 32'hA5A5_0001, 14'h004, BUS_ACC_4B, 32'h5A5A_0002, 2, 1, 3, 2);
    d_op(1'b0, 14'h100, BUS_ACC_4B, 32'h0, 32'hDEAD_BEEF, ALL);
    i_op(14'h300, BUS_ACC_4B, 32'hCAFE_F00D);

    idle(6);
    chk("sb_outstanding", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
